dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_responder_if.sv | 47 ++++
 rtl/dbus_responder.sv | 183 ++++++++++++++++++
 tb/tb_dbus_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_responder_if.sv
// dbus_responder_if -- command/response bundle for the data-bus responder.
//
// Signals:
//   dbus_cmd_valid  master -> slave  command present
//   dbus_cmd_ready  slave  -> master responder accepts a command this cycle
//   dbus_cmd_addr   master -> slave  byte address (32 bit)
//   dbus_cmd_data   master -> slave  write data, byte lane i = bits 8i+7:8i
//   dbus_cmd_size   master -> slave  byte-lane mask, bit i = lane i
//   dbus_cmd_we     master -> slave  1 = write, 0 = read
//   dbus_rsp_data   slave  -> master read data
//   dbus_rsp_valid  slave  -> master one-cycle response strobe, no backpressure
//   dbus_rsp_error  slave  -> master qualifies dbus_rsp_valid, 1 = failed command
interface dbus_responder_if;
    logic        dbus_cmd_valid;
    logic        dbus_cmd_ready;
    logic [31:0] dbus_cmd_addr;
    logic [31:0] dbus_cmd_data;
    logic [3:0]  dbus_cmd_size;
    logic        dbus_cmd_we;
    logic [31:0] dbus_rsp_data;
    logic        dbus_rsp_valid;
    logic        dbus_rsp_error;

    modport master (
        output dbus_cmd_valid,
        input  dbus_cmd_ready,
        output dbus_cmd_addr,
        output dbus_cmd_data,
        output dbus_cmd_size,
        output dbus_cmd_we,
        input  dbus_rsp_data,
        input  dbus_rsp_valid,
        input  dbus_rsp_error
    );

    modport slave (
        input  dbus_cmd_valid,
        output dbus_cmd_ready,
        input  dbus_cmd_addr,
        input  dbus_cmd_data,
        input  dbus_cmd_size,
        input  dbus_cmd_we,
        output dbus_rsp_data,
        output dbus_rsp_valid,
        output dbus_rsp_error
    );
endinterface

// File: rtl/dbus_responder.sv
// dbus_responder -- word-organised memory behind a single-outstanding data bus.
//
// Legal writes update the selected byte lanes at the accept edge and produce
// no response. Reads (legal or not) and erroneous writes produce exactly one
// response strobe LATENCY cycles after the accept edge. Only one command can
// be in flight: the responder is ready only while idle.
//
// Parameters:
//   DEPTH      memory size in 32-bit words (power of two, 4..65536)
//   LATENCY    cycles from read accept to response (1..8)
//   BASE_ADDR  byte address of word 0 (word aligned)
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rstf  synchronous active-high reset
//   bus   dbus_responder_if slave modport (command in, response out)
//
// States:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ready for a command; legal writes complete here
//   ST_WAIT | response pending, countdown running toward terminal count 1
//   ST_RESP | response strobe driven for this single cycle
module dbus_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstf,
    dbus_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    mask_q, mask_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          mask_legal;
    logic          below_base;
    logic          misaligned;
    logic          out_of_range;
    logic          cmd_err;
    logic          needs_rsp;
    logic          mem_we;
    logic [31:0]   cmd_offset;
    logic [AW-1:0] cmd_idx;
    logic [31:0]   rsp_word;
    logic          rsp_active;

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b[8*i +: 8] = {8{m[i]}};
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign accept = bus.dbus_cmd_valid & bus.dbus_cmd_ready;

    always_comb begin
        mask_legal = 1'b0;
        case (bus.dbus_cmd_size)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: mask_legal = 1'b1;
            default:                   mask_legal = 1'b0;
        endcase
    end

    // Below-base is a plain compare so the subtraction wrap below never
    // masquerades as a small, in-range offset.
    assign below_base   = bus.dbus_cmd_addr < BASE_ADDR;
    assign cmd_offset   = bus.dbus_cmd_addr - BASE_ADDR;
    // BASE_ADDR is word aligned, so the offset's low bits equal the address's.
    assign misaligned   = cmd_offset[1:0] != 2'b00;
    assign out_of_range = {2'b00, cmd_offset[31:2]} >= 32'(DEPTH);
    assign cmd_idx      = cmd_offset[AW+1:2];

    assign cmd_err   = ~mask_legal | misaligned | below_base | out_of_range;
    assign mem_we    = accept & bus.dbus_cmd_we & ~cmd_err;
    assign needs_rsp = accept & ~(bus.dbus_cmd_we & ~cmd_err);

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.dbus_cmd_size[i]) begin
                    mem[cmd_idx][8*i +: 8] <= bus.dbus_cmd_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstf) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (needs_rsp) begin
                    idx_d   = cmd_idx;
                    mask_d  = bus.dbus_cmd_size;
                    err_d   = cmd_err;
                    count_d = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count_q == 4'd1) begin
                    count_d = '0;
                    state_d = ST_RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gating with rstf keeps ready and the response quiet for the whole
    // reset cycle, even if the register still holds a pre-reset state.
    assign rsp_active = (state_q == ST_RESP) & ~rstf;

    // No write can be accepted while a response is pending, so reading the
    // latched word now returns the contents at accept time.
    assign rsp_word = mem[idx_q] & lane_bits(mask_q);

    assign bus.dbus_cmd_ready = (state_q == ST_IDLE) & ~rstf;
    assign bus.dbus_rsp_valid = rsp_active;
    assign bus.dbus_rsp_error = rsp_active & err_q;
    assign bus.dbus_rsp_data  = (rsp_active & ~err_q) ? rsp_word : 32'h0;
endmodule

// File: tb/tb_dbus_responder.sv
module tb_dbus_responder;
    logic clk;
    logic rstf;

    dbus_responder_if bus_a ();
    dbus_responder_if bus_b ();

    // A: LATENCY 2, 1024 words at 0. B: LATENCY 1, 16 words at 0x100.
    dbus_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk  (clk),
        .rstf (rstf),
        .bus  (bus_a.slave)
    );

    dbus_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h0000_0100)) dut_b (
        .clk  (clk),
        .rstf (rstf),
        .bus  (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        bit          rsp;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] mask, input bit rsp, input bit err,
                                input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.mask = mask;
        v.rsp = rsp; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic valid, input vec_t v);
        if (!sel) begin
            bus_a.dbus_cmd_valid = valid;
            bus_a.dbus_cmd_we    = v.we;
            bus_a.dbus_cmd_addr  = v.addr;
            bus_a.dbus_cmd_data  = v.data;
            bus_a.dbus_cmd_size  = v.mask;
        end else begin
            bus_b.dbus_cmd_valid = valid;
            bus_b.dbus_cmd_we    = v.we;
            bus_b.dbus_cmd_addr  = v.addr;
            bus_b.dbus_cmd_data  = v.data;
            bus_b.dbus_cmd_size  = v.mask;
        end
    endtask

    // One command through the selected DUT; checks ready, strobe timing,
    // data and error in every cycle up to the expected response.
    task automatic run_cmd(input bit sel, input vec_t v, input string name);
        int          lat;
        logic        rdy, rv, re;
        logic [31:0] rd;
        bit          exp_v;
        lat = sel ? 1 : 2;
        @(posedge clk); #1;
        drive(sel, 1'b1, v);
        @(negedge clk);
        rdy = sel ? bus_b.dbus_cmd_ready : bus_a.dbus_cmd_ready;
        rv  = sel ? bus_b.dbus_rsp_valid : bus_a.dbus_rsp_valid;
        chk({name, "_ready_idle"}, 32'(rdy), 32'd1);
        chk({name, "_quiet_idle"}, 32'(rv), 32'd0);
        @(posedge clk); #1;
        drive(sel, 1'b0, v);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            rdy = sel ? bus_b.dbus_cmd_ready : bus_a.dbus_cmd_ready;
            rv  = sel ? bus_b.dbus_rsp_valid : bus_a.dbus_rsp_valid;
            re  = sel ? bus_b.dbus_rsp_error : bus_a.dbus_rsp_error;
            rd  = sel ? bus_b.dbus_rsp_data  : bus_a.dbus_rsp_data;
            exp_v = v.rsp && (k == lat);
            chk($sformatf("%s_valid_c%0d", name, k), 32'(rv), 32'(exp_v));
            chk($sformatf("%s_ready_c%0d", name, k), 32'(rdy), v.rsp ? 32'd0 : 32'd1);
            if (exp_v) begin
                chk({name, "_err"},  32'(re), 32'(v.err));
                chk({name, "_data"}, rd, v.rdata);
            end else begin
                chk($sformatf("%s_data0_c%0d", name, k), rd, 32'h0);
            end
        end
    endtask

    vec_t va[$];

    initial begin
        vec_t v;

        // Table for DUT A (LATENCY 2, base 0, 1024 words), values by hand.
        va.push_back(mk(1, 32'h10,   32'hDEADBEEF, 4'b1111, 0, 0, 32'h0));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b1111, 1, 0, 32'hDEADBEEF));
        va.push_back(mk(1, 32'h10,   32'h00AA0000, 4'b0100, 0, 0, 32'h0));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b1111, 1, 0, 32'hDEAABEEF));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b1100, 1, 0, 32'hDEAA0000));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b0011, 1, 0, 32'h0000BEEF));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b0001, 1, 0, 32'h000000EF));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b1000, 1, 0, 32'hDE000000));
        va.push_back(mk(0, 32'h12,   32'h0,        4'b0011, 1, 1, 32'h0));
        va.push_back(mk(0, 32'h1000, 32'h0,        4'b1111, 1, 1, 32'h0));
        va.push_back(mk(1, 32'h10,   32'hFFFFFFFF, 4'b0101, 1, 1, 32'h0));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b1111, 1, 0, 32'hDEAABEEF));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b0000, 1, 1, 32'h0));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b1001, 1, 1, 32'h0));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b0110, 1, 1, 32'h0));
        va.push_back(mk(1, 32'hFFC,  32'h12345678, 4'b1111, 0, 0, 32'h0));
        va.push_back(mk(0, 32'hFFC,  32'h0,        4'b1111, 1, 0, 32'h12345678));
        va.push_back(mk(0, 32'h13,   32'h0,        4'b1111, 1, 1, 32'h0));
        va.push_back(mk(1, 32'h1000, 32'h55555555, 4'b1111, 1, 1, 32'h0));
        va.push_back(mk(1, 32'h0,    32'h01020304, 4'b1111, 0, 0, 32'h0));
        va.push_back(mk(0, 32'h0,    32'h0,        4'b0010, 1, 0, 32'h00000300));
        va.push_back(mk(1, 32'h0,    32'hAB000000, 4'b1000, 0, 0, 32'h0));
        va.push_back(mk(0, 32'h0,    32'h0,        4'b1111, 1, 0, 32'hAB020304));
        va.push_back(mk(1, 32'h10,   32'h11112222, 4'b0011, 0, 0, 32'h0));
        va.push_back(mk(0, 32'h10,   32'h0,        4'b1111, 1, 0, 32'hDEAA2222));

        v = mk(0, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h0);
        drive(0, 1'b0, v);
        drive(1, 1'b0, v);

        // Reset: ready and response quiet while rstf is high.
        rstf = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a", 32'(bus_a.dbus_cmd_ready), 32'd0);
        chk("rst_ready_b", 32'(bus_b.dbus_cmd_ready), 32'd0);
        chk("rst_valid_a", 32'(bus_a.dbus_rsp_valid), 32'd0);
        chk("rst_error_a", 32'(bus_a.dbus_rsp_error), 32'd0);
        chk("rst_data_a",  bus_a.dbus_rsp_data,       32'h0);
        @(posedge clk); #1;
        rstf = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_a", 32'(bus_a.dbus_cmd_ready), 32'd1);
        chk("post_rst_ready_b", 32'(bus_b.dbus_cmd_ready), 32'd1);

        foreach (va[i]) run_cmd(0, va[i], $sformatf("A%0d", i));

        // Valid low in IDLE with moving fields: nothing happens.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, mk(i[0], 32'h10, 32'hFFFF0000 + 32'(i), 4'b1111, 0, 0, 32'h0));
            @(negedge clk);
            chk($sformatf("idle_quiet_%0d", i), 32'(bus_a.dbus_rsp_valid), 32'd0);
            chk($sformatf("idle_ready_%0d", i), 32'(bus_a.dbus_cmd_ready), 32'd1);
        end
        run_cmd(0, mk(0, 32'h10, 32'h0, 4'b1111, 1, 0, 32'hDEAA2222), "idle_noeffect");

        // Streaming writes with valid held: one accept per cycle, no strobes.
        @(posedge clk); #1;
        drive(0, 1'b1, mk(1, 32'h20, 32'h10000000, 4'b1111, 0, 0, 32'h0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stream_ready_%0d", i), 32'(bus_a.dbus_cmd_ready), 32'd1);
            chk($sformatf("stream_quiet_%0d", i), 32'(bus_a.dbus_rsp_valid), 32'd0);
            @(posedge clk); #1;
            drive(0, i < 3, mk(1, 32'h24 + 32'(4*i), 32'h10000001 + 32'(i), 4'b1111, 0, 0, 32'h0));
        end
        @(negedge clk);
        chk("stream_tail_quiet", 32'(bus_a.dbus_rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_cmd(0, mk(0, 32'h20 + 32'(4*i), 32'h0, 4'b1111, 1, 0, 32'h10000000 + 32'(i)),
                    $sformatf("stream_rd%0d", i));
        end

        // Reset while A is in WAIT: pending response is dropped.
        @(posedge clk); #1;
        drive(0, 1'b1, mk(0, 32'h10, 32'h0, 4'b1111, 0, 0, 32'h0));
        @(posedge clk); #1;
        drive(0, 1'b0, mk(0, 32'h10, 32'h0, 4'b1111, 0, 0, 32'h0));
        rstf = 1'b1;
        @(negedge clk);
        chk("wait_rst_ready", 32'(bus_a.dbus_cmd_ready), 32'd0);
        chk("wait_rst_valid", 32'(bus_a.dbus_rsp_valid), 32'd0);
        @(posedge clk); #1;
        rstf = 1'b0;
        @(negedge clk);
        chk("wait_rst_ready_after", 32'(bus_a.dbus_cmd_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wait_rst_norsp_%0d", i), 32'(bus_a.dbus_rsp_valid), 32'd0);
            @(negedge clk);
        end
        run_cmd(0, mk(0, 32'h10, 32'h0, 4'b1111, 1, 0, 32'hDEAA2222), "wait_rst_readback");

        // DUT B (LATENCY 1, base 0x100, 16 words): setup and range edges.
        run_cmd(1, mk(1, 32'h100, 32'hA5A5A5A5, 4'b1111, 0, 0, 32'h0), "B_wr0");
        run_cmd(1, mk(1, 32'h13C, 32'h5A5A5A5A, 4'b1111, 0, 0, 32'h0), "B_wr15");
        run_cmd(1, mk(0, 32'h13C, 32'h0,        4'b1111, 1, 0, 32'h5A5A5A5A), "B_rd15");
        run_cmd(1, mk(0, 32'hFC,  32'h0,        4'b1111, 1, 1, 32'h0), "B_below");
        run_cmd(1, mk(0, 32'h140, 32'h0,        4'b1111, 1, 1, 32'h0), "B_above");
        run_cmd(1, mk(1, 32'h0,   32'h0,        4'b1111, 1, 1, 32'h0), "B_wr_low");
        run_cmd(1, mk(0, 32'h100, 32'h0,        4'b1100, 1, 0, 32'hA5A50000), "B_rd0");

        // B back-to-back reads with valid held: accept every other cycle.
        @(posedge clk); #1;
        drive(1, 1'b1, mk(0, 32'h100, 32'h0, 4'b1111, 0, 0, 32'h0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_%0d", i), 32'(bus_b.dbus_cmd_ready), 32'(i % 2 == 0));
            chk($sformatf("b2b_valid_%0d", i), 32'(bus_b.dbus_rsp_valid), 32'(i % 2 == 1));
            chk($sformatf("b2b_data_%0d", i),  bus_b.dbus_rsp_data,
                (i % 2 == 1) ? 32'hA5A5A5A5 : 32'h0);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, mk(0, 32'h100, 32'h0, 4'b1111, 0, 0, 32'h0));

        // Reset while B is in RESP: strobe suppressed during reset.
        @(posedge clk); #1;
        drive(1, 1'b1, mk(0, 32'h13C, 32'h0, 4'b1111, 0, 0, 32'h0));
        @(posedge clk); #1;
        drive(1, 1'b0, mk(0, 32'h13C, 32'h0, 4'b1111, 0, 0, 32'h0));
        rstf = 1'b1;
        @(negedge clk);
        chk("resp_rst_valid", 32'(bus_b.dbus_rsp_valid), 32'd0);
        chk("resp_rst_data",  bus_b.dbus_rsp_data,       32'h0);
        @(posedge clk); #1;
        rstf = 1'b0;
        @(negedge clk);
        chk("resp_rst_ready_after", 32'(bus_b.dbus_cmd_ready), 32'd1);
        chk("resp_rst_norsp",       32'(bus_b.dbus_rsp_valid), 32'd0);
        run_cmd(1, mk(0, 32'h13C, 32'h0, 4'b0011, 1, 0, 32'h00005A5A), "B_readback");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
